// File: rtl/bf_io_pkg.sv
// Shared definitions for the brainfuck core's I/O peripherals: the UART
// transmitter state encoding, the character width and the frame lengths of
// both line formats (plain 8N1 and 8E1 with BF_TX_PARITY_EN defined).
package bf_io_pkg;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS_NO_PARITY = 10;
    localparam int FRAME_BITS_PARITY    = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Even parity bit for one character: makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// Generic single-clock FIFO with a first-word-fall-through head: dout always
// shows the oldest entry while the FIFO is non-empty. A push into a full FIFO
// is accepted only when a pop happens on the same edge.
module bf_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_COUNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: written at the tail, left unreset so it can map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap modulo depth; the occupancy counter carries one extra bit
    // so that a full FIFO is distinguishable from an empty one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bf_uart_tx.sv
// UART transmitter for the brainfuck core's '.' output strobes. Characters
// are queued in a small FIFO and sent as 8N1 frames on tx; when the macro
// BF_TX_PARITY_EN is defined an even parity bit is inserted before the stop
// bit (8E1). Back-to-back frames run with no idle gap while the FIFO has data.
module bf_uart_tx
    import bf_io_pkg::*;
#(
    parameter int CLK_DIV         = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sendingChar,
    input  logic [7:0]                sendedChar,
    output logic                      tx,
    output logic                      busy,
    output logic [FIFO_DEPTH_LOG2:0]  fifo_count,
    output logic                      overflow
);

    localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        LAST_BIT    = 3'(DATA_BITS - 1);

    tx_state_t              state;
    tx_state_t              state_n;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [BAUD_W-1:0]      baud_n;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_n;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_n;
    logic                   tx_q;
    logic                   tx_n;
`ifdef BF_TX_PARITY_EN
    logic                   parity_q;
    logic                   parity_n;
`endif

    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   baud_done;

    bf_sync_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sendingChar),
        .pop   (fifo_pop),
        .din   (sendedChar),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_done = (baud_cnt == '0);
    assign tx        = tx_q;
    assign busy      = (state != IDLE) | (fifo_count != '0);

    // Next-state logic: each non-idle state lasts CLK_DIV cycles; a waiting
    // character is popped from IDLE or straight from the end of STOP, and the
    // registered tx level is derived from the state being entered.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_idx;
        shift_n  = shift_q;
        fifo_pop = 1'b0;
        tx_n     = 1'b1;
`ifdef BF_TX_PARITY_EN
        parity_n = parity_q;
`endif

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_dout;
`ifdef BF_TX_PARITY_EN
                    parity_n = even_parity(fifo_dout);
`endif
                    state_n  = START;
                    baud_n   = BAUD_RELOAD;
                end
            end

            START: begin
                if (baud_done) begin
                    state_n = DATA;
                    baud_n  = BAUD_RELOAD;
                    bit_n   = '0;
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end

            DATA: begin
                if (baud_done) begin
                    baud_n = BAUD_RELOAD;
                    if (bit_idx == LAST_BIT) begin
`ifdef BF_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n   = bit_idx + 1'b1;
                        shift_n = shift_q >> 1;
                    end
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end

`ifdef BF_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_n = STOP;
                    baud_n  = BAUD_RELOAD;
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
`endif

            STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_n  = fifo_dout;
`ifdef BF_TX_PARITY_EN
                        parity_n = even_parity(fifo_dout);
`endif
                        state_n  = START;
                        baud_n   = BAUD_RELOAD;
                    end else begin
                        state_n = IDLE;
                        baud_n  = '0;
                    end
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                baud_n  = '0;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef BF_TX_PARITY_EN
            PARITY:  tx_n = parity_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    // Frame registers; reset aborts any frame in flight and parks tx high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef BF_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift_q  <= shift_n;
            tx_q     <= tx_n;
`ifdef BF_TX_PARITY_EN
            parity_q <= parity_n;
`endif
        end
    end

    // Sticky drop flag: a strobe into a full FIFO with no pop on that edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (sendingChar && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Self-checking bench for bf_uart_tx (CLK_DIV=4, 4-entry FIFO). A table of
// single characters with hand-written line levels is applied first, followed
// by hand-written sequences for back-to-back frames, overflow, reset
// mid-frame and pointer wrap-around. Define BF_TX_PARITY_EN to test 8E1.
module tb_bf_uart_tx;
    import bf_io_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int DEPTH_LOG2 = 2;
`ifdef BF_TX_PARITY_EN
    localparam int FRAME_LEN  = FRAME_BITS_PARITY;
`else
    localparam int FRAME_LEN  = FRAME_BITS_NO_PARITY;
`endif
    localparam int FRAME_CYC  = FRAME_LEN * CLK_DIV;
    localparam int NVEC       = 8;

    typedef struct {
        logic [7:0]           ch;
        logic [0:FRAME_LEN-1] lv;
    } vec_t;

    logic                clk;
    logic                reset;
    logic                sendingChar;
    logic [7:0]          sendedChar;
    logic                tx;
    logic                busy;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                overflow;

    int total;
    int bad;

    logic [7:0]           rx_q[$];
    int                   start_q[$];
    logic [0:FRAME_LEN-1] last_lv;
    logic [7:0]           last_rx;
    int                   cyc;

    logic track_en;
    int   peak;
    int   busy_low;

    vec_t vecs[NVEC];

    bf_uart_tx #(
        .CLK_DIV         (CLK_DIV),
        .FIFO_DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sendingChar (sendingChar),
        .sendedChar  (sendedChar),
        .tx          (tx),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence never finishes.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 300000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] ch);
        sendingChar = 1'b1;
        sendedChar  = ch;
        @(posedge clk);
        #1;
        sendingChar = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            idleCycles(1);
            n++;
        end
        checkOutput("wait_idle", busy, 1'b0);
    endtask

    // Line monitor: captures whole frames at the falling clock edge, checks
    // every bit holds for CLK_DIV cycles, and decodes the character.
    initial begin
        logic                 samples [FRAME_CYC];
        logic [0:FRAME_LEN-1] lv;
        logic [7:0]           d;
        int                   unstable;
        int                   mon_n;
        logic                 mon_active;
        mon_active = 1'b0;
        mon_n      = 0;
        cyc        = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset !== 1'b1) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    samples[0] = tx;
                    mon_n      = 1;
                    start_q.push_back(cyc);
                end
            end else begin
                samples[mon_n] = tx;
                mon_n++;
                if (mon_n == FRAME_CYC) begin
                    unstable = 0;
                    for (int b = 0; b < FRAME_LEN; b++) begin
                        lv[b] = samples[b*CLK_DIV];
                        for (int c = 1; c < CLK_DIV; c++) begin
                            if (samples[b*CLK_DIV + c] !== lv[b]) unstable++;
                        end
                    end
                    for (int i = 0; i < 8; i++) d[i] = lv[1+i];
                    checkOutput("frame_bit_stable", unstable, 0);
                    checkOutput("frame_stop_bit", lv[FRAME_LEN-1], 1'b1);
`ifdef BF_TX_PARITY_EN
                    checkOutput("frame_parity_bit", lv[9], ^d);
`endif
                    last_lv = lv;
                    last_rx = d;
                    rx_q.push_back(d);
                    mon_active = 1'b0;
                end
            end
        end
    end

    // Tracks FIFO peak occupancy and any busy dropout while enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (track_en) begin
                if (int'(fifo_count) > peak) peak = int'(fifo_count);
                if (busy !== 1'b1) busy_low++;
            end
        end
    end

    // Main sequence.
    initial begin
        int base;
        int sbase;
        int n;
        logic [31:0] got;

        total       = 0;
        bad         = 0;
        track_en    = 1'b0;
        peak        = 0;
        busy_low    = 0;
        reset       = 1'b0;
        sendingChar = 1'b0;
        sendedChar  = 8'h00;

        // Line levels in time order: start, d0..d7, [parity,] stop.
`ifdef BF_TX_PARITY_EN
        vecs[0] = '{8'h41, 11'b0_10000010_0_1};
        vecs[1] = '{8'h55, 11'b0_10101010_0_1};
        vecs[2] = '{8'hAA, 11'b0_01010101_0_1};
        vecs[3] = '{8'h0F, 11'b0_11110000_0_1};
        vecs[4] = '{8'h00, 11'b0_00000000_0_1};
        vecs[5] = '{8'hFF, 11'b0_11111111_0_1};
        vecs[6] = '{8'h03, 11'b0_11000000_0_1};
        vecs[7] = '{8'h07, 11'b0_11100000_1_1};
`else
        vecs[0] = '{8'h41, 10'b0_10000010_1};
        vecs[1] = '{8'h55, 10'b0_10101010_1};
        vecs[2] = '{8'hAA, 10'b0_01010101_1};
        vecs[3] = '{8'h0F, 10'b0_11110000_1};
        vecs[4] = '{8'h00, 10'b0_00000000_1};
        vecs[5] = '{8'hFF, 10'b0_11111111_1};
        vecs[6] = '{8'h03, 10'b0_11000000_1};
        vecs[7] = '{8'h07, 10'b0_11100000_1};
`endif

        idleCycles(3);
        checkOutput("reset_tx", tx, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_count", fifo_count, 0);
        checkOutput("reset_overflow", overflow, 1'b0);
        reset = 1'b1;
        idleCycles(2);

        $display("[TB] single-character table");
        for (int i = 0; i < NVEC; i++) begin
            base = rx_q.size();
            applyStimulus(vecs[i].ch);
            checkOutput("push_count", fifo_count, 1);
            checkOutput("push_tx_idle", tx, 1'b1);
            checkOutput("push_busy", busy, 1'b1);
            idleCycles(1);
            checkOutput("pop_tx_start", tx, 1'b0);
            checkOutput("pop_count", fifo_count, 0);
            idleCycles(FRAME_CYC - 1);
            checkOutput("last_stop_busy", busy, 1'b1);
            checkOutput("last_stop_tx", tx, 1'b1);
            idleCycles(1);
            checkOutput("after_frame_busy", busy, 1'b0);
            checkOutput("rx_frames", rx_q.size() - base, 1);
            checkOutput("frame_levels", last_lv, vecs[i].lv);
            checkOutput("rx_byte", last_rx, vecs[i].ch);
            idleCycles(2);
        end

        $display("[TB] back-to-back frames");
        base     = rx_q.size();
        sbase    = start_q.size();
        peak     = 0;
        busy_low = 0;
        applyStimulus(8'h55);
        track_en = 1'b1;
        idleCycles(2);
        applyStimulus(8'hAA);
        idleCycles(2);
        applyStimulus(8'h0F);
        n = 0;
        while (rx_q.size() - base < 3 && n < 4 * FRAME_CYC) begin
            idleCycles(1);
            n++;
        end
        track_en = 1'b0;
        checkOutput("b2b_frames", rx_q.size() - base, 3);
        checkOutput("b2b_peak_count", peak, 2);
        checkOutput("b2b_busy_dropouts", busy_low, 0);
        got = (rx_q.size() > base + 2) ? rx_q[base]   : 32'hFFFF_FFFF;
        checkOutput("b2b_byte0", got, 8'h55);
        got = (rx_q.size() > base + 2) ? rx_q[base+1] : 32'hFFFF_FFFF;
        checkOutput("b2b_byte1", got, 8'hAA);
        got = (rx_q.size() > base + 2) ? rx_q[base+2] : 32'hFFFF_FFFF;
        checkOutput("b2b_byte2", got, 8'h0F);
        got = (start_q.size() > sbase + 2) ? start_q[sbase+1] - start_q[sbase]   : 0;
        checkOutput("b2b_gap01", got, FRAME_CYC);
        got = (start_q.size() > sbase + 2) ? start_q[sbase+2] - start_q[sbase+1] : 0;
        checkOutput("b2b_gap12", got, FRAME_CYC);
        waitIdle(2 * FRAME_CYC);
        idleCycles(2);

        $display("[TB] overflow");
        base = rx_q.size();
        for (int i = 0; i < 6; i++) begin
            sendingChar = 1'b1;
            sendedChar  = 8'(8'h30 + i);
            @(posedge clk);
            #1;
            if (i == 4) begin
                checkOutput("full_count", fifo_count, 4);
                checkOutput("overflow_before_drop", overflow, 1'b0);
            end
        end
        sendingChar = 1'b0;
        checkOutput("overflow_set", overflow, 1'b1);
        checkOutput("overflow_count", fifo_count, 4);
        waitIdle(6 * FRAME_CYC);
        idleCycles(1);
        checkOutput("overflow_frames", rx_q.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            got = (rx_q.size() > base + i) ? rx_q[base+i] : 32'hFFFF_FFFF;
            checkOutput("overflow_byte", got, 8'(8'h30 + i));
        end
        checkOutput("overflow_sticky", overflow, 1'b1);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 3; i++) begin
            sendingChar = 1'b1;
            sendedChar  = (i == 0) ? 8'h41 : ((i == 1) ? 8'h11 : 8'h22);
            @(posedge clk);
            #1;
        end
        sendingChar = 1'b0;
        checkOutput("queued_count", fifo_count, 2);
        idleCycles(16);
        checkOutput("mid_bit3_level", tx, 1'b0);
        base  = rx_q.size();
        reset = 1'b0;
        idleCycles(1);
        checkOutput("midreset_tx", tx, 1'b1);
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_count", fifo_count, 0);
        checkOutput("midreset_overflow", overflow, 1'b0);
        reset = 1'b1;
        idleCycles(2);
        checkOutput("postreset_tx", tx, 1'b1);
        applyStimulus(8'h42);
        waitIdle(2 * FRAME_CYC);
        idleCycles(1);
        checkOutput("postreset_frames", rx_q.size() - base, 1);
        checkOutput("postreset_byte", last_rx, 8'h42);

        $display("[TB] pointer wrap-around");
        base = rx_q.size();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 3; j++) begin
                sendingChar = 1'b1;
                sendedChar  = 8'(8'hC0 + (b*3 + j) * 7);
                @(posedge clk);
                #1;
            end
            sendingChar = 1'b0;
            waitIdle(4 * FRAME_CYC);
            idleCycles(1);
        end
        checkOutput("wrap_frames", rx_q.size() - base, 12);
        for (int i = 0; i < 12; i++) begin
            got = (rx_q.size() > base + i) ? rx_q[base+i] : 32'hFFFF_FFFF;
            checkOutput("wrap_byte", got, 8'(8'hC0 + i * 7));
        end
        checkOutput("wrap_overflow", overflow, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
